// File: rtl/wb_uart_tx8_if.sv
// Wishbone B3 8-bit slave bus bundle for the transmit UART.
// Signal names keep the slave-side _i/_o suffixes of the SoC port.
interface wb_uart_tx8_if;
  logic [2:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic       wb_we_i;
  logic       wb_cyc_i;
  logic       wb_stb_i;
  logic [2:0] wb_cti_i;
  logic [1:0] wb_bte_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;
  logic       wb_err_o;
  logic       wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i,
    output wb_cyc_i, wb_stb_i,
    output wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o,
    input  wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i,
    input  wb_cyc_i, wb_stb_i,
    input  wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o,
    output wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_uart_tx8.sv
// 8-bit Wishbone transmit-only UART: THR FIFO, IER/LSR/SCR,
// 8N1 serializer and THR-empty interrupt.
module wb_uart_tx8 #(
  parameter int CLK_DIV         = 16,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  wb_uart_tx8_if.slave  wb,
  output logic          tx_o,
  output logic          irq_o
);

  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        irq_q, irq_d;

  logic        ack_q, ack_d;
  logic [7:0]  dat_q, dat_d;
  logic        ier_q, ier_d;
  logic [7:0]  scr_q, scr_d;

  logic        empty;
  logic        full;
  logic        req;
  logic        thr_wr;
  logic        acc;
  logic        push;
  logic        pop;
  logic [7:0]  rd_val;
  logic        unused_bus;

  assign unused_bus = ^{wb.wb_cti_i, wb.wb_bte_i};

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign pop    = (state_q == IDLE) && !empty;
  assign req    = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign thr_wr = req & wb.wb_we_i & (wb.wb_adr_i == 3'd0);
  // A full FIFO stalls the THR write unless the serializer frees a slot now.
  assign acc    = req & ~(thr_wr & full & ~pop);
  assign push   = acc & thr_wr;

  always_comb begin
    rd_val = 8'h00;
    unique case (wb.wb_adr_i)
      3'd1:    rd_val = {6'b0, ier_q, 1'b0};
      3'd5:    rd_val = {1'b0, empty & (state_q == IDLE),
                         empty, 5'b0};
      3'd7:    rd_val = scr_q;
      default: rd_val = 8'h00;
    endcase
  end

  always_comb begin
    ack_d  = acc;
    dat_d  = acc ? rd_val : 8'h00;
    ier_d  = ier_q;
    scr_d  = scr_q;
    if (acc && wb.wb_we_i && wb.wb_adr_i == 3'd1)
      ier_d = wb.wb_dat_i[1];
    if (acc && wb.wb_we_i && wb.wb_adr_i == 3'd7)
      scr_d = wb.wb_dat_i;
    wptr_d = wptr_q + {{AW{1'b0}}, push};
    rptr_d = rptr_q + {{AW{1'b0}}, pop};
    irq_d  = ier_q & empty;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          shift_d = mem_q[rptr_q[AW-1:0]];
          cnt_d   = DIV_M1;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = DIV_M1;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = DIV_M1;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7)
            state_d = STOP;
          else
            idx_d = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == 16'd0)
          state_d = IDLE;
        else
          cnt_d = cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the state one cycle later, so tx_o is glitch-free.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (push)
      mem_q[wptr_q[AW-1:0]] <= wb.wb_dat_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      irq_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= 8'h00;
      ier_q   <= 1'b0;
      scr_q   <= 8'h00;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      irq_q   <= irq_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      ier_q   <= ier_d;
      scr_q   <= scr_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_err_o = 1'b0;
  assign wb.wb_rty_o = 1'b0;
  assign tx_o        = tx_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_wb_uart_tx8.sv
// Bench for wb_uart_tx8: timeline model of FIFO/frames/irq,
// per-cycle line and irq compare, directed register accesses.
module tb_wb_uart_tx8;
  localparam int D     = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
  logic irq;

  wb_uart_tx8_if bus ();

  wb_uart_tx8 #(
    .CLK_DIV(D),
    .FIFO_DEPTH_LOG2(4)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_n_i(rst_n),
    .wb(bus.slave),
    .tx_o(tx),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  int ec = 0;
  always @(posedge clk) ec <= ec + 1;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Model: per byte, the edge it enters the FIFO and the edge it is popped.
  int         push_e[$];
  int         pop_e[$];
  logic [7:0] q_b[$];
  int         last_pop;
  bit         ier_old, ier_new;
  int         ier_e;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d",
               nm, act, exp, ec);
    end
  endtask

  function automatic void model_clear();
    push_e.delete();
    pop_e.delete();
    q_b.delete();
    last_pop = -100000;
    ier_old  = 0;
    ier_new  = 0;
    ier_e    = 0;
  endfunction

  function automatic logic mtx(int e);
    logic [7:0] v;
    int b;
    foreach (pop_e[i]) begin
      if (e >= pop_e[i] + 1 && e <= pop_e[i] + 10 * D) begin
        b = (e - pop_e[i] - 1) / D;
        v = q_b[i];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return v[b-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic bit mempty(int x);
    foreach (push_e[i])
      if (push_e[i] <= x && pop_e[i] > x) return 0;
    return 1;
  endfunction

  function automatic bit ier_at(int x);
    return (x >= ier_e) ? ier_new : ier_old;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_line", tx, mtx(ec));
      chk("irq_line", irq, ier_at(ec - 1) & mempty(ec - 1));
      chk("err_o", bus.wb_err_o, 0);
      chk("rty_o", bus.wb_rty_o, 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_until(int e);
    while (ec < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after an edge; the request is sampled at the next edge.
  task automatic bus_acc(input logic [2:0] adr, input logic we,
                         input logic [7:0] d, output logic [7:0] rd,
                         output int ae);
    int r, exp, cnt, pn;
    r   = ec + 1;
    exp = r;
    if (we && adr == 3'd0) begin
      cnt = 0;
      foreach (push_e[i])
        if (push_e[i] <= r - 1 && pop_e[i] > r - 1) cnt++;
      if (cnt >= DEPTH) begin
        exp = -1;
        foreach (pop_e[i])
          if (exp < 0 && pop_e[i] >= r) exp = pop_e[i];
      end
      pn = exp + 1;
      if (last_pop + 10 * D + 1 > pn) pn = last_pop + 10 * D + 1;
      push_e.push_back(exp);
      pop_e.push_back(pn);
      q_b.push_back(d);
      last_pop = pn;
    end
    if (we && adr == 3'd1) begin
      ier_old = ier_new;
      ier_new = d[1];
      ier_e   = exp;
    end
    bus.wb_adr_i = adr;
    bus.wb_dat_i = d;
    bus.wb_we_i  = we;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    ae = -1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (bus.wb_ack_o) begin
        ae = ec;
        break;
      end
    end
    chk("ack_edge", ae, exp);
    rd = bus.wb_dat_o;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    @(posedge clk);
    #1;
    chk("ack_once", bus.wb_ack_o, 0);
  endtask

  logic [7:0] rd;
  int a, ae, w, k0;
  int ae_arr[18];
  int lows;
  int exp_bits[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

  initial begin
    bus.wb_adr_i = 3'd0;
    bus.wb_dat_i = 8'h00;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_cti_i = 3'b000;
    bus.wb_bte_i = 2'b00;
    model_clear();

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1;
    chk("rst_tx", tx, 1);
    chk("rst_irq", irq, 0);
    chk("rst_ack", bus.wb_ack_o, 0);
    bus_acc(3'd5, 1'b0, 8'h00, rd, ae);
    chk("lsr_reset", rd, 8'h60);

    // Single byte 0x55
    bus_acc(3'd0, 1'b1, 8'h55, rd, a);
    chk("pre_start", tx, 1);
    wait_until(a + 2);
    chk("start_edge", tx, 0);
    bus_acc(3'd5, 1'b0, 8'h00, rd, ae);
    chk("lsr_busy", rd, 8'h20);
    for (int k = 0; k < 10; k++) begin
      wait_until(a + 2 + D * k + D / 2);
      chk("frame55_bit", tx, exp_bits[k]);
    end
    wait_until(a + 2 + 10 * D);
    bus_acc(3'd5, 1'b0, 8'h00, rd, ae);
    chk("lsr_done", rd, 8'h60);

    // Interrupt
    bus_acc(3'd1, 1'b1, 8'h02, rd, w);
    chk("irq_set", irq, 1);
    bus_acc(3'd1, 1'b0, 8'h00, rd, ae);
    chk("ier_read", rd, 8'h02);
    bus_acc(3'd0, 1'b1, 8'hA5, rd, a);
    chk("irq_push", irq, 0);
    @(posedge clk);
    #1;
    chk("irq_pop", irq, 1);
    wait_until(a + 2 + 10 * D + 2);

    // Scratch and unmapped
    bus_acc(3'd7, 1'b1, 8'hC3, rd, ae);
    bus_acc(3'd7, 1'b0, 8'h00, rd, ae);
    chk("scr_read", rd, 8'hC3);
    bus_acc(3'd3, 1'b1, 8'hFF, rd, ae);
    bus_acc(3'd3, 1'b0, 8'h00, rd, ae);
    chk("adr3_read", rd, 8'h00);
    bus_acc(3'd0, 1'b0, 8'h00, rd, ae);
    chk("thr_read", rd, 8'h00);
    bus_acc(3'd1, 1'b1, 8'hFF, rd, ae);
    bus_acc(3'd1, 1'b0, 8'h00, rd, ae);
    chk("ier_mask", rd, 8'h02);

    // FIFO full stall: byte 0 is popped at once, so byte 17 finds 16 queued
    for (int i = 0; i < 18; i++)
      bus_acc(3'd0, 1'b1, 8'(i), rd, ae_arr[i]);
    chk("stall_ack", ae_arr[17], ae_arr[0] + 2 + 10 * D);
    wait_until(last_pop + 10 * D + 2);
    bus_acc(3'd5, 1'b0, 8'h00, rd, ae);
    chk("lsr_drained", rd, 8'h60);

    // Reset during data bit 4 of the first of three queued frames
    bus_acc(3'd0, 1'b1, 8'h3C, rd, a);
    bus_acc(3'd0, 1'b1, 8'h81, rd, ae);
    bus_acc(3'd0, 1'b1, 8'h7E, rd, ae);
    k0 = a + 1;
    wait_until(k0 + 5 * D + 3);
    rst_n = 1'b0;
    @(posedge clk);
    model_clear();
    #1;
    chk("rst_mid_tx", tx, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus_acc(3'd5, 1'b0, 8'h00, rd, ae);
    chk("lsr_after_rst", rd, 8'h60);
    bus_acc(3'd1, 1'b0, 8'h00, rd, ae);
    chk("ier_after_rst", rd, 8'h00);
    bus_acc(3'd7, 1'b0, 8'h00, rd, ae);
    chk("scr_after_rst", rd, 8'h00);
    lows = 0;
    repeat (400) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) lows++;
    end
    chk("no_frames", lows, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
